// File: rtl/accumulator_param_if.sv
// +----------------------------------------------------------------------+
// | accumulator_param_if : operand stream and result bus                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface accumulator_param_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
);
   logic             i_start;
   logic [LEN_W-1:0] i_len;
   logic             i_clr;
   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic             i_sub;
   logic             o_ready;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_ovf;
   logic [LEN_W-1:0] o_cnt;

   // Operand source / result consumer side
   modport master (
      output i_start, i_len, i_clr, i_valid, i_data, i_sub,
      input  o_ready, o_busy, o_done, o_sum, o_carry, o_ovf, o_cnt
   );

   // Accumulator side
   modport slave (
      input  i_start, i_len, i_clr, i_valid, i_data, i_sub,
      output o_ready, o_busy, o_done, o_sum, o_carry, o_ovf, o_cnt
   );
endinterface

`default_nettype wire

// File: rtl/accumulator_param.sv
// +----------------------------------------------------------------------+
// | accumulator_param : signed burst accumulator, FSM + datapath         |
// | Optional saturation on overflow via macro ACC_SAT_EN                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module accumulator_param #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  wire logic           i_clk,
   input  wire logic           i_rst,
   accumulator_param_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [LEN_W-1:0] c_cnt_one = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_ovf;

   logic             w_ready;
   logic             w_done;
   logic             w_start_load;
   logic             w_beat;
   logic [LEN_W-1:0] w_cnt_inc;
   logic [WIDTH:0]   w_raw_add;
   logic [WIDTH:0]   w_raw_sub;
   logic [WIDTH:0]   w_raw;
   logic             w_sign_a;
   logic             w_sign_d;
   logic             w_sign_r;
   logic             w_ovf_beat;
   logic             w_carry_beat;
   logic [WIDTH-1:0] w_result;

   // Datapath arithmetic: borrow of A-D equals the top bit of the extended difference
   assign w_raw_add    = {1'b0, r_sum} + {1'b0, bus.i_data};
   assign w_raw_sub    = {1'b0, r_sum} - {1'b0, bus.i_data};
   assign w_raw        = bus.i_sub ? w_raw_sub : w_raw_add;
   assign w_carry_beat = w_raw[WIDTH];
   assign w_sign_a     = r_sum[WIDTH-1];
   assign w_sign_d     = bus.i_data[WIDTH-1];
   assign w_sign_r     = w_raw[WIDTH-1];
   assign w_ovf_beat   = bus.i_sub ? ((w_sign_a != w_sign_d) && (w_sign_r != w_sign_a))
                                   : ((w_sign_a == w_sign_d) && (w_sign_r != w_sign_a));

`ifdef ACC_SAT_EN
   // Overflow direction follows the accumulator sign before the beat
   assign w_result = w_ovf_beat ? (w_sign_a ? c_sat_min : c_sat_max) : w_raw[WIDTH-1:0];
`else
   assign w_result = w_raw[WIDTH-1:0];
`endif

   assign w_cnt_inc = r_cnt + c_cnt_one;
   assign w_beat    = w_ready && bus.i_valid && !bus.i_clr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_done       = 1'b0;
      w_start_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_start_load = 1'b1;
               w_next_state = (bus.i_len == '0) ? ST_DONE : ST_ACC;
            end
         end
         ST_ACC: begin
            w_ready = 1'b1;
            if (bus.i_valid && (w_cnt_inc == r_len)) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
      // Abort overrides any start or end-of-burst transition
      if (bus.i_clr) begin
         w_next_state = ST_IDLE;
         w_start_load = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_len   <= '0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (bus.i_clr) begin
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_start_load) begin
         r_len   <= bus.i_len;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_beat) begin
         r_cnt   <= w_cnt_inc;
         r_sum   <= w_result;
         r_carry <= w_carry_beat;
         r_ovf   <= r_ovf | w_ovf_beat;
      end
   end

   assign bus.o_ready = w_ready;
   assign bus.o_busy  = (r_state != ST_IDLE);
   assign bus.o_done  = w_done;
   assign bus.o_sum   = r_sum;
   assign bus.o_carry = r_carry;
   assign bus.o_ovf   = r_ovf;
   assign bus.o_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_accumulator_param.sv
// +----------------------------------------------------------------------+
// | tb_accumulator_param : randomized bench with behavioural model       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_accumulator_param;

   localparam int WIDTH = 8;
   localparam int LEN_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   accumulator_param_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus();

   accumulator_param #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: true signed value of the accumulator and flags
   int m_sum;
   int m_cnt;
   bit m_carry;
   bit m_ovf;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_start = 1'b0;
      bus.i_len   = '0;
      bus.i_clr   = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_sub   = 1'b0;
   endtask

   task automatic model_clear();
      m_sum = 0; m_cnt = 0; m_carry = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_beat(input int d, input bit sub);
      int a_u, d_u, t;
      logic [WIDTH-1:0] t8;
      a_u = m_sum & 255;
      d_u = d & 255;
      if (sub) begin
         t = m_sum - d;
         m_carry = (a_u < d_u);
      end else begin
         t = m_sum + d;
         m_carry = ((a_u + d_u) > 255);
      end
      if (t > 127 || t < -128) begin
         m_ovf = 1'b1;
`ifdef ACC_SAT_EN
         m_sum = (t > 127) ? 127 : -128;
`else
         t8 = t[WIDTH-1:0];
         m_sum = int'($signed(t8));
`endif
      end else begin
         m_sum = t;
      end
      m_cnt = m_cnt + 1;
   endtask

   task automatic start_burst(input int len);
      logic [WIDTH-1:0] es;
      bus.i_start = 1'b1;
      bus.i_len   = len[LEN_W-1:0];
      tick();
      bus.i_start = 1'b0;
      model_clear();
      es = '0;
      checks++;
      if ({bus.o_busy, bus.o_ready, bus.o_done, bus.o_sum, bus.o_cnt, bus.o_carry, bus.o_ovf}
          !== {1'b1, (len != 0), (len == 0), es, {LEN_W{1'b0}}, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL start len=%0d: busy=%b ready=%b done=%b sum=%h cnt=%0d c=%b o=%b",
                  len, bus.o_busy, bus.o_ready, bus.o_done, bus.o_sum, bus.o_cnt,
                  bus.o_carry, bus.o_ovf);
      end
   endtask

   task automatic beat(input int d, input bit sub);
      logic [WIDTH-1:0] es;
      logic [LEN_W-1:0] ec;
      bus.i_valid = 1'b1;
      bus.i_data  = d[WIDTH-1:0];
      bus.i_sub   = sub;
      tick();
      bus.i_valid = 1'b0;
      model_beat(d, sub);
      es = m_sum[WIDTH-1:0];
      ec = m_cnt[LEN_W-1:0];
      checks++;
      if ({bus.o_sum, bus.o_carry, bus.o_ovf, bus.o_cnt} !== {es, m_carry, m_ovf, ec}) begin
         errors++;
         $display("FAIL beat d=%0d sub=%b: sum=%h c=%b o=%b cnt=%0d, want sum=%h c=%b o=%b cnt=%0d",
                  d, sub, bus.o_sum, bus.o_carry, bus.o_ovf, bus.o_cnt, es, m_carry, m_ovf, ec);
      end
   endtask

   task automatic gap(input bit poke_start);
      logic [WIDTH-1:0] es;
      logic [LEN_W-1:0] ec;
      bus.i_valid = 1'b0;
      bus.i_data  = WIDTH'($urandom);
      bus.i_sub   = 1'($urandom);
      bus.i_start = poke_start;
      bus.i_len   = LEN_W'($urandom);
      tick();
      bus.i_start = 1'b0;
      es = m_sum[WIDTH-1:0];
      ec = m_cnt[LEN_W-1:0];
      checks++;
      if ({bus.o_ready, bus.o_busy, bus.o_sum, bus.o_cnt} !== {1'b1, 1'b1, es, ec}) begin
         errors++;
         $display("FAIL gap: ready=%b busy=%b sum=%h cnt=%0d, want ready=1 busy=1 sum=%h cnt=%0d",
                  bus.o_ready, bus.o_busy, bus.o_sum, bus.o_cnt, es, ec);
      end
   endtask

   task automatic finish_burst();
      logic [WIDTH-1:0] es;
      es = m_sum[WIDTH-1:0];
      checks++;
      if ({bus.o_done, bus.o_ready, bus.o_busy} !== 3'b101) begin
         errors++;
         $display("FAIL done_pulse: done=%b ready=%b busy=%b, want 1 0 1",
                  bus.o_done, bus.o_ready, bus.o_busy);
      end
      tick();
      checks++;
      if ({bus.o_done, bus.o_ready, bus.o_busy, bus.o_sum} !== {3'b000, es}) begin
         errors++;
         $display("FAIL done_end: done=%b ready=%b busy=%b sum=%h, want 0 0 0 sum=%h",
                  bus.o_done, bus.o_ready, bus.o_busy, bus.o_sum, es);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      checks++;
      if ({bus.o_sum, bus.o_cnt, bus.o_carry, bus.o_ovf, bus.o_done, bus.o_ready, bus.o_busy} !== '0) begin
         errors++;
         $display("FAIL reset: sum=%h cnt=%0d c=%b o=%b done=%b ready=%b busy=%b, want all 0",
                  bus.o_sum, bus.o_cnt, bus.o_carry, bus.o_ovf, bus.o_done, bus.o_ready, bus.o_busy);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_add_ovf();
      logic [WIDTH-1:0] want;
`ifdef ACC_SAT_EN
      want = 8'h7F;
`else
      want = 8'hA0;
`endif
      start_burst(2);
      beat(80, 1'b0);
      beat(80, 1'b0);
      checks++;
      if ({bus.o_sum, bus.o_carry, bus.o_ovf, bus.o_cnt} !== {want, 1'b0, 1'b1, 4'd2}) begin
         errors++;
         $display("FAIL add_ovf: sum=%h c=%b o=%b cnt=%0d, want sum=%h c=0 o=1 cnt=2",
                  bus.o_sum, bus.o_carry, bus.o_ovf, bus.o_cnt, want);
      end
      finish_burst();
   endtask

   task automatic test_sub_borrow();
      start_burst(2);
      beat(10, 1'b0);
      beat(20, 1'b1);
      checks++;
      if ({bus.o_sum, bus.o_carry, bus.o_ovf} !== {8'hF6, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sub_borrow: sum=%h c=%b o=%b, want sum=f6 c=1 o=0",
                  bus.o_sum, bus.o_carry, bus.o_ovf);
      end
      finish_burst();
   endtask

   task automatic test_neg_ovf();
      logic [WIDTH-1:0] want;
`ifdef ACC_SAT_EN
      want = 8'h80;
`else
      want = 8'h6A;
`endif
      start_burst(2);
      beat(-50, 1'b0);
      beat(-100, 1'b0);
      checks++;
      if ({bus.o_sum, bus.o_carry, bus.o_ovf} !== {want, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL neg_ovf: sum=%h c=%b o=%b, want sum=%h c=1 o=1",
                  bus.o_sum, bus.o_carry, bus.o_ovf, want);
      end
      finish_burst();
   endtask

   task automatic test_valid_gaps();
      start_burst(3);
      beat(1, 1'b0);
      gap(1'b1);
      beat(2, 1'b0);
      gap(1'b0);
      beat(3, 1'b0);
      checks++;
      if ({bus.o_sum, bus.o_cnt} !== {8'd6, 4'd3}) begin
         errors++;
         $display("FAIL valid_gaps: sum=%h cnt=%0d, want sum=06 cnt=3", bus.o_sum, bus.o_cnt);
      end
      finish_burst();
   endtask

   task automatic test_len_zero();
      start_burst(0);
      finish_burst();
      checks++;
      if ({bus.o_sum, bus.o_cnt} !== '0) begin
         errors++;
         $display("FAIL len_zero: sum=%h cnt=%0d, want 0 0", bus.o_sum, bus.o_cnt);
      end
   endtask

   task automatic test_abort(input bit use_rst);
      int seen_done;
      start_burst(4);
      beat(int'($urandom_range(0, 255)) - 128, 1'($urandom));
      beat(int'($urandom_range(0, 255)) - 128, 1'($urandom));
      if (use_rst) begin
         #2 rst = 1'b1;
         #1;
      end else begin
         bus.i_clr   = 1'b1;
         bus.i_valid = 1'b1;
         bus.i_data  = 8'd5;
         tick();
         bus.i_clr   = 1'b0;
         bus.i_valid = 1'b0;
      end
      checks++;
      if ({bus.o_sum, bus.o_cnt, bus.o_carry, bus.o_ovf, bus.o_done, bus.o_ready, bus.o_busy} !== '0) begin
         errors++;
         $display("FAIL abort(rst=%b): sum=%h cnt=%0d c=%b o=%b done=%b ready=%b busy=%b, want all 0",
                  use_rst, bus.o_sum, bus.o_cnt, bus.o_carry, bus.o_ovf, bus.o_done,
                  bus.o_ready, bus.o_busy);
      end
      if (use_rst) begin
         tick();
         rst = 1'b0;
      end
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.o_done) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL abort_no_done(rst=%b): done seen %0d cycles, want 0", use_rst, seen_done);
      end
      if (!use_rst) begin
         // Clear and start together in IDLE: clear wins
         bus.i_clr = 1'b1; bus.i_start = 1'b1; bus.i_len = 4'd3;
         tick();
         bus.i_clr = 1'b0; bus.i_start = 1'b0;
         checks++;
         if (bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_start: busy=%b, want 0", bus.o_busy);
         end
      end
      start_burst(2);
      beat(7, 1'b0);
      beat(3, 1'b1);
      finish_burst();
   endtask

   task automatic test_random();
      int len;
      for (int b = 0; b < 25; b++) begin
         len = int'($urandom_range(1, (1 << LEN_W) - 1));
         start_burst(len);
         for (int k = 0; k < len; k++) begin
            for (int g = 0; g < 3; g++) begin
               if ($urandom_range(0, 2) == 0) gap(1'($urandom));
            end
            beat(int'($urandom_range(0, 255)) - 128, 1'($urandom));
         end
         finish_burst();
      end
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_sub_borrow();
      test_neg_ovf();
      test_valid_gaps();
      test_len_zero();
      test_abort(1'b1);
      test_abort(1'b0);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/accumulator_param.md
Name: accumulator_param

Overview:
- Parametrised successor to the fixed 8-bit accumulator.
- Signed accumulator of programmable burst length, with controller FSM and datapath in one module.
- Accepts a stream of signed operands over a valid/ready handshake. Each operand is added or subtracted per beat.
- Reports sum, carry/borrow and sticky signed overflow, and pulses done at end of burst. Sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8: operand/accumulator width in bits (signed, two's complement), >= 2.
- LEN_W, 4: width of the burst-length field; max burst = 2^LEN_W - 1 beats.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start a burst (sampled in IDLE only).
- i_len  in  LEN_W  number of beats in burst (sampled with i_start).
- i_clr  in  1  synchronous abort/clear.
- i_valid  in  1  operand valid.
- i_data  in  WIDTH  signed operand.
- i_sub  in  1  1 = subtract i_data this beat, 0 = add (qualified by i_valid).
- o_ready  out  1  block can accept an operand this cycle.
- o_busy  out  1  burst in progress (state != IDLE).
- o_done  out  1  one-cycle pulse at end of burst.
- o_sum  out  WIDTH  accumulator value, signed.
- o_carry  out  1  carry (add) / borrow (sub) of the most recent accepted beat.
- o_ovf  out  1  sticky signed overflow for the current burst.
- o_cnt  out  LEN_W  beats accepted so far in the current burst.

Behaviour:
- Reset (i_rst = 1, asynchronous): state = IDLE; o_sum, o_cnt, o_carry, o_ovf, o_done, o_ready = 0.
- One clock, i_clk; reset asynchronous, active-high.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - o_ready = 0; i_valid ignored; o_sum and flags hold the last burst's result.
  - On i_start with i_len != 0: latch i_len; clear o_sum, o_cnt, o_carry, o_ovf to 0; go to ACC.
  - On i_start with i_len == 0: clear the same registers; go directly to DONE (empty burst, sum 0).
- ACC:
  - o_ready = 1. A beat transfers when i_valid and o_ready are both 1 at a rising edge.
  - Per beat: o_sum <= result; o_cnt++; o_carry <= carry/borrow; o_ovf <= o_ovf | ovf_beat.
  - On the beat where o_cnt + 1 == latched len: go to DONE. o_ready drops the following cycle.
  - No beat transfers while i_valid = 0; state and registers hold.
- DONE: o_done = 1 for exactly one cycle; o_ready = 0; next state IDLE. Results hold until the next start.
- Latency: a beat accepted at edge k is visible on o_sum after edge k. o_done is high during the cycle after the last beat.
- Arithmetic, with A = o_sum and D = i_data:
  - Add: raw = A + D (WIDTH+1 bits, unsigned view). carry = raw[WIDTH]. ovf_beat = sign(A) == sign(D) and sign(raw) != sign(A).
  - Sub: raw = A - D. carry = borrow = (unsigned A < unsigned D). ovf_beat = sign(A) != sign(D) and sign(raw) != sign(A).
  - Result = raw[WIDTH-1:0] (wrap), unless saturation is enabled (see Optional Feature).
- i_start outside IDLE is ignored; the burst continues unaffected.
- i_clr (any state) has priority over i_start and beats:
  - Next state IDLE; o_sum, o_cnt, o_carry, o_ovf cleared; no o_done pulse.
  - i_clr and i_start in the same IDLE cycle: clear wins, no start.
- o_cnt does not wrap; a burst never exceeds 2^LEN_W - 1 beats.
- Reset mid-burst: immediate return to IDLE with reset values; no done pulse after release.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: on ovf_beat, the result clamps to 2^(WIDTH-1)-1 on positive overflow or -2^(WIDTH-1) on negative overflow. o_ovf is still set; o_carry is unchanged (computed from raw).
- Not defined: result wraps modulo 2^WIDTH. All other behaviour is identical.

Test Plan:
- WIDTH=8, start len=2; beats +80, +80 (add) -> o_sum=-96 (0xA0), o_carry=0, o_ovf=1, o_done pulses once, o_cnt=2. With ACC_SAT_EN: o_sum=127.
- Start len=2; beats +10 add, then 20 sub -> o_sum=-10, o_carry=1 (borrow), o_ovf=0.
- Start len=2; beats -50, -100 -> o_sum=106 (wrapped), o_carry=1, o_ovf=1. With ACC_SAT_EN: o_sum=-128.
- Start len=3; i_valid toggles 1,0,1,0,1 with beats 1,2,3 -> o_sum=6 only after the third transfer. i_start pulsed mid-burst has no effect. o_ready low in IDLE/DONE.
- Start len=0 -> o_done one cycle after start, o_sum=0, o_cnt=0, no o_ready.
- Start len=4, accept 2 beats, then assert i_rst (and separately i_clr) -> all outputs 0, state IDLE, no o_done. A new burst afterwards works from sum 0.
